// File: rtl/clkgate_ctrl.sv
// Clock-enable controller for a BUFGCE-style buffer: merges requests into ce,
// acks requesters once the gated clock has been running for ON_DLY cycles.
module clkgate_ctrl #(
  parameter int N_REQ    = 4,
  parameter int ON_DLY   = 4,
  parameter int IDLE_DLY = 16,
  parameter int CNT_W    = 8,
  parameter int WCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              force_on,
  output logic [N_REQ-1:0]  ack,
  output logic              ce,
  output logic              busy,
  output logic [WCNT_W-1:0] wake_cnt
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  ON_LOAD   = CNT_W'(ON_DLY - 1);
  localparam logic [CNT_W-1:0]  IDLE_LOAD = CNT_W'(IDLE_DLY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = {WCNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               ce_q, ce_d;
  logic               busy_q, busy_d;
  logic               any_s;

  // Next-state, delay counter, wake counter and registered-output decode
  always_comb begin
    any_s      = (|req) | force_on;
    state_d    = state_q;
    cnt_d      = cnt_q;
    wake_cnt_d = wake_cnt_q;

    case (state_q)
      ST_OFF: begin
        if (any_s) begin
          state_d = ST_WAKE;
          cnt_d   = ON_LOAD;
          if (wake_cnt_q != WCNT_MAX) begin
            wake_cnt_d = wake_cnt_q + WCNT_ONE;
          end else begin
            wake_cnt_d = wake_cnt_q;
          end
        end else begin
          state_d = ST_OFF;
        end
      end
      // WAKE runs to completion regardless of req so the buffer always gets its start-up time
      ST_WAKE: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ON: begin
        if (!any_s) begin
          state_d = ST_HOLD;
          cnt_d   = IDLE_LOAD;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_HOLD: begin
        if (any_s) begin
          state_d = ST_ON;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    // ce/busy follow the next state so ce rises with WAKE entry and falls with OFF entry
    ce_d   = (state_d != ST_OFF);
    busy_d = (state_d != ST_OFF);
    if (state_q == ST_ON) begin
      ack_d = req;
    end else begin
      ack_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      wake_cnt_q <= '0;
      ack_q      <= '0;
      ce_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wake_cnt_q <= wake_cnt_d;
      ack_q      <= ack_d;
      ce_q       <= ce_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign ce       = ce_q;
  assign busy     = busy_q;
  assign wake_cnt = wake_cnt_q;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed bench for clkgate_ctrl: expectations are queued when stimulus is
// driven and popped/compared #1 after the following clock edge.
module tb_clkgate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [3:0]  req, req2;
  logic        force_on, force2;
  logic [3:0]  ack, ack2;
  logic        ce, ce2, busy, busy2;
  logic [15:0] wake_cnt;
  logic [1:0]  wake_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        sel;
    logic [3:0]  ack;
    logic        ce;
    logic        busy;
    logic [15:0] wk;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  clkgate_ctrl #(.N_REQ(4), .ON_DLY(4), .IDLE_DLY(16), .CNT_W(8), .WCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .force_on(force_on),
    .ack(ack), .ce(ce), .busy(busy), .wake_cnt(wake_cnt)
  );

  clkgate_ctrl #(.N_REQ(4), .ON_DLY(4), .IDLE_DLY(16), .CNT_W(8), .WCNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .force_on(force2),
    .ack(ack2), .ce(ce2), .busy(busy2), .wake_cnt(wake_cnt2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic sel, input logic [3:0] a,
                            input logic c, input logic b, input logic [15:0] w);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ack = a; e.ce = c; e.busy = b; e.wk = w;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [3:0]  oa;
    logic        oc, ob;
    logic [15:0] ow;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed 0 entries expected >=1");
    end else begin
      e  = sb_q.pop_front();
      oa = e.sel ? ack2  : ack;
      oc = e.sel ? ce2   : ce;
      ob = e.sel ? busy2 : busy;
      ow = e.sel ? {14'd0, wake_cnt2} : wake_cnt;
      checks++;
      assert (oa === e.ack) else begin
        errors++; $error("FAIL %s.ack observed %b expected %b", e.tag, oa, e.ack);
      end
      checks++;
      assert (oc === e.ce) else begin
        errors++; $error("FAIL %s.ce observed %b expected %b", e.tag, oc, e.ce);
      end
      checks++;
      assert (ob === e.busy) else begin
        errors++; $error("FAIL %s.busy observed %b expected %b", e.tag, ob, e.busy);
      end
      checks++;
      assert (ow === e.wk) else begin
        errors++; $error("FAIL %s.wake_cnt observed %0d expected %0d", e.tag, ow, e.wk);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    req = 4'b0000; req2 = 4'b0000;
    force_on = 1'b0; force2 = 1'b0;

    // Reset state and idle after release
    #12;
    expect_out("rst_init", 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0); check_out();
    @(posedge clk); #1;
    rst_n = 1'b1; rst2_n = 1'b1;
    expect_out("rst_idle", 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0);
    step(3); check_out();

    // Wake-up latency: req after edge 0
    req = 4'b0001;
    expect_out("wake_e1", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd1); step(1); check_out();
    expect_out("wake_e4", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd1); step(3); check_out();
    expect_out("on_e5",   1'b0, 4'b0000, 1'b1, 1'b1, 16'd1); step(1); check_out();
    expect_out("ack_e6",  1'b0, 4'b0001, 1'b1, 1'b1, 16'd1); step(1); check_out();
    expect_out("ack_e20", 1'b0, 4'b0001, 1'b1, 1'b1, 16'd1); step(14); check_out();

    // Gate-off timing
    req = 4'b0000;
    expect_out("hold_e21", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd1); step(1); check_out();
    expect_out("hold_e36", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd1); step(15); check_out();
    expect_out("off_e37",  1'b0, 4'b0000, 1'b0, 1'b0, 16'd1); step(1); check_out();

    // HOLD rescue: second wake, req[2] arrives mid-HOLD
    req = 4'b0001;
    expect_out("wake2_e20", 1'b0, 4'b0001, 1'b1, 1'b1, 16'd2); step(20); check_out();
    req = 4'b0000;
    expect_out("hold2_e30", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2); step(10); check_out();
    req = 4'b0100;
    expect_out("rescue_e31", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2); step(1); check_out();
    expect_out("rescue_e32", 1'b0, 4'b0100, 1'b1, 1'b1, 16'd2); step(1); check_out();
    expect_out("rescue_e47", 1'b0, 4'b0100, 1'b1, 1'b1, 16'd2); step(15); check_out();

    // Multi-request, then force_on
    req = 4'b1011;
    expect_out("multi_ack", 1'b0, 4'b1011, 1'b1, 1'b1, 16'd2); step(1); check_out();
    force_on = 1'b1; req = 4'b0000;
    expect_out("force_noack", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2); step(1); check_out();
    for (int i = 0; i < 100; i++) begin
      expect_out("force_hold", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2); step(1); check_out();
    end
    req = 4'b0010;
    expect_out("force_ack", 1'b0, 4'b0010, 1'b1, 1'b1, 16'd2); step(1); check_out();
    req = 4'b0000;
    expect_out("force_drop", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2); step(1); check_out();
    force_on = 1'b0;
    expect_out("unforce_hold", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2); step(1); check_out();
    expect_out("unforce_last", 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2); step(15); check_out();
    expect_out("unforce_off",  1'b0, 4'b0000, 1'b0, 1'b0, 16'd2); step(1); check_out();

    // Reset asserted mid-HOLD
    req = 4'b0001;
    expect_out("wake3_on", 1'b0, 4'b0001, 1'b1, 1'b1, 16'd3); step(8); check_out();
    req = 4'b0000;
    step(5);
    rst_n = 1'b0; #1;
    expect_out("rst_hold_now", 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0); check_out();
    expect_out("rst_hold_in",  1'b0, 4'b0000, 1'b0, 1'b0, 16'd0); step(2); check_out();
    rst_n = 1'b1;
    expect_out("rst_hold_out", 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0); step(5); check_out();

    // Saturating wake counter on the 2-bit instance; req drops inside WAKE
    for (int k = 1; k <= 5; k++) begin
      req2 = 4'b0001;
      expect_out("sat_wake", 1'b1, 4'b0000, 1'b1, 1'b1, (k > 3) ? 16'd3 : 16'(k));
      step(1); check_out();
      req2 = 4'b0000;
      expect_out("sat_off", 1'b1, 4'b0000, 1'b0, 1'b0, (k > 3) ? 16'd3 : 16'(k));
      step(25); check_out();
    end

    // Reset mid-WAKE: ce drops at once, no late ack
    req2 = 4'b0001;
    step(2);
    rst2_n = 1'b0; #1;
    expect_out("rst_wake_now", 1'b1, 4'b0000, 1'b0, 1'b0, 16'd0); check_out();
    step(2);
    req2 = 4'b0000;
    rst2_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_out("rst_wake_after", 1'b1, 4'b0000, 1'b0, 1'b0, 16'd0); step(1); check_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
